// File: rtl/mem_pkg.sv
// Shared encodings and sizing helpers for the MEM response stage.
package mem_pkg;

    localparam int LD_OP_W = 3;

    localparam logic [LD_OP_W-1:0] LD_NONE = 3'd0;
    localparam logic [LD_OP_W-1:0] LD_B    = 3'd1;
    localparam logic [LD_OP_W-1:0] LD_BU   = 3'd2;
    localparam logic [LD_OP_W-1:0] LD_H    = 3'd3;
    localparam logic [LD_OP_W-1:0] LD_HU   = 3'd4;
    localparam logic [LD_OP_W-1:0] LD_W    = 3'd5;

    // Bits needed to count 0..max_out discarded responses.
    function automatic int cancel_cnt_w(input int max_out);
        return (max_out < 1) ? 1 : $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load extraction: selects the byte/halfword lane and extends it to DATA_W.
module mem_load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]  data,
    input  logic [1:0]         addr_low,
    input  logic [LD_OP_W-1:0] ld_op,
    output logic [DATA_W-1:0]  result
);

    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [DATA_W-1:0] word_val;

    function automatic logic [DATA_W-1:0] ext8(input logic [7:0] v, input logic sgn);
        logic signed [7:0] sv;
        sv = v;
        return {{(DATA_W-8){sgn & sv[7]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] ext16(input logic [15:0] v, input logic sgn);
        logic signed [15:0] sv;
        sv = v;
        return {{(DATA_W-16){sgn & sv[15]}}, v};
    endfunction

    assign byte_lane = data[{addr_low, 3'b000} +: 8];
    assign half_lane = data[{addr_low[1], 4'b0000} +: 16];

    // Wider datapaths sign-extend the 32-bit word, matching ld.w semantics.
    if (DATA_W > 32) begin : g_word_wide
        assign word_val = {{(DATA_W-32){data[31]}}, data[31:0]};
    end else begin : g_word_narrow
        assign word_val = data;
    end

    always_comb begin
        result = word_val;
        case (ld_op)
            LD_B:    result = ext8(byte_lane, 1'b1);
            LD_BU:   result = ext8(byte_lane, 1'b0);
            LD_H:    result = ext16(half_lane, 1'b1);
            LD_HU:   result = ext16(half_lane, 1'b0);
            default: result = word_val;
        endcase
    end

endmodule

// File: rtl/mem_resp_stage.sv
// MEM pipeline stage with split-transaction data-SRAM response handling,
// response buffering under WB stall, and cancellation of responses owed to flushed loads.
module mem_resp_stage
    import mem_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int PAYLOAD_W       = 168,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 es_to_ms_valid,
    output logic                 ms_allowin,
    input  logic [PAYLOAD_W-1:0] es_payload,
    input  logic [LD_OP_W-1:0]   es_ld_op,
    input  logic                 es_wait_resp,
    input  logic [1:0]           es_addr_low,
    input  logic [DATA_W-1:0]    es_result,
    input  logic [4:0]           es_dest,
    input  logic                 es_gr_we,
    input  logic                 es_cancel_inc,
    input  logic                 data_sram_data_ok,
    input  logic [DATA_W-1:0]    data_sram_rdata,
    input  logic                 ws_allowin,
    input  logic                 flush,
    output logic                 ms_to_ws_valid,
    output logic [PAYLOAD_W-1:0] ms_payload,
    output logic [4:0]           ms_dest,
    output logic                 ms_gr_we,
    output logic [DATA_W-1:0]    ms_final_result,
    output logic                 ms_fwd_valid,
    output logic                 ms_fwd_stall,
    output logic                 cancel_busy
);

    localparam int CNT_W = cancel_cnt_w(MAX_OUTSTANDING);

    logic                 ms_valid_p1;
    logic                 buf_valid_p1;
    logic [CNT_W-1:0]     cancel_cnt;
    logic [CNT_W-1:0]     cancel_cnt_nxt;

    logic [PAYLOAD_W-1:0] payload_p1;
    logic [LD_OP_W-1:0]   ld_op_p1;
    logic                 wait_p1;
    logic [1:0]           addr_low_p1;
    logic [DATA_W-1:0]    result_p1;
    logic [4:0]           dest_p1;
    logic                 gr_we_p1;
    logic [DATA_W-1:0]    buf_p1;

    logic                 own_ok;
    logic                 ms_ready_go;
    logic                 capture;
    logic                 flush_owed;
    logic                 cancel_drop;
    logic [DATA_W-1:0]    load_data;
    logic [DATA_W-1:0]    load_val;

    assign own_ok      = data_sram_data_ok && (cancel_cnt == '0) && ms_valid_p1
                         && wait_p1 && !buf_valid_p1;
    assign ms_ready_go = !wait_p1 || buf_valid_p1 || own_ok;

    assign ms_to_ws_valid = ms_valid_p1 && ms_ready_go && !flush;
    assign ms_allowin     = !ms_valid_p1 || (ms_ready_go && ws_allowin) || flush;
    assign capture        = es_to_ms_valid && ms_allowin && !flush;

    // A response still owed by the flushed instruction must be swallowed later.
    assign flush_owed  = flush && ms_valid_p1 && wait_p1 && !buf_valid_p1 && !own_ok;
    assign cancel_drop = data_sram_data_ok && (cancel_cnt != '0);

    assign cancel_cnt_nxt = cancel_cnt + CNT_W'(flush_owed) + CNT_W'(es_cancel_inc)
                            - CNT_W'(cancel_drop);

    // ---- Control state (EX -> MEM boundary) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_p1  <= 1'b0;
            buf_valid_p1 <= 1'b0;
            cancel_cnt   <= '0;
        end else begin
            cancel_cnt <= cancel_cnt_nxt;
            if (ms_allowin) begin
                ms_valid_p1 <= es_to_ms_valid && !flush;
            end
            if (flush || ms_allowin) begin
                buf_valid_p1 <= 1'b0;
            end else if (own_ok && !ws_allowin) begin
                buf_valid_p1 <= 1'b1;
            end
        end
    end

    // ---- Data registers (EX -> MEM boundary), qualified by ms_valid_p1 ----
    always_ff @(posedge clk) begin
        if (capture) begin
            payload_p1  <= es_payload;
            ld_op_p1    <= es_ld_op;
            wait_p1     <= es_wait_resp;
            addr_low_p1 <= es_addr_low;
            result_p1   <= es_result;
            dest_p1     <= es_dest;
            gr_we_p1    <= es_gr_we;
        end
        if (own_ok && !ws_allowin) begin
            buf_p1 <= data_sram_rdata;
        end
    end

    assign load_data = buf_valid_p1 ? buf_p1 : data_sram_rdata;

    mem_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .data     (load_data),
        .addr_low (addr_low_p1),
        .ld_op    (ld_op_p1),
        .result   (load_val)
    );

    // ---- MEM -> WB / forwarding outputs ----
    assign ms_payload      = payload_p1;
    assign ms_dest         = dest_p1;
    assign ms_gr_we        = gr_we_p1;
    assign ms_final_result = (ld_op_p1 != LD_NONE) ? load_val : result_p1;
    assign ms_fwd_valid    = ms_valid_p1 && gr_we_p1 && (dest_p1 != 5'd0);
    assign ms_fwd_stall    = ms_fwd_valid && (ld_op_p1 != LD_NONE) && !ms_ready_go;
    assign cancel_busy     = (cancel_cnt != '0);

endmodule

// File: tb/tb_mem_resp_stage.sv
// Directed bench for mem_resp_stage: loads, buffering, flush cancellation and reset.
module tb_mem_resp_stage;
    import mem_pkg::*;

    localparam int DATA_W          = 32;
    localparam int PAYLOAD_W       = 168;
    localparam int MAX_OUTSTANDING = 2;

    logic                 clk;
    logic                 reset;
    logic                 es_to_ms_valid;
    logic                 ms_allowin;
    logic [PAYLOAD_W-1:0] es_payload;
    logic [LD_OP_W-1:0]   es_ld_op;
    logic                 es_wait_resp;
    logic [1:0]           es_addr_low;
    logic [DATA_W-1:0]    es_result;
    logic [4:0]           es_dest;
    logic                 es_gr_we;
    logic                 es_cancel_inc;
    logic                 data_sram_data_ok;
    logic [DATA_W-1:0]    data_sram_rdata;
    logic                 ws_allowin;
    logic                 flush;
    logic                 ms_to_ws_valid;
    logic [PAYLOAD_W-1:0] ms_payload;
    logic [4:0]           ms_dest;
    logic                 ms_gr_we;
    logic [DATA_W-1:0]    ms_final_result;
    logic                 ms_fwd_valid;
    logic                 ms_fwd_stall;
    logic                 cancel_busy;

    int n_cmp = 0;
    int n_bad = 0;

    mem_resp_stage #(
        .DATA_W          (DATA_W),
        .PAYLOAD_W       (PAYLOAD_W),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allowin        (ms_allowin),
        .es_payload        (es_payload),
        .es_ld_op          (es_ld_op),
        .es_wait_resp      (es_wait_resp),
        .es_addr_low       (es_addr_low),
        .es_result         (es_result),
        .es_dest           (es_dest),
        .es_gr_we          (es_gr_we),
        .es_cancel_inc     (es_cancel_inc),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allowin        (ws_allowin),
        .flush             (flush),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_payload        (ms_payload),
        .ms_dest           (ms_dest),
        .ms_gr_we          (ms_gr_we),
        .ms_final_result   (ms_final_result),
        .ms_fwd_valid      (ms_fwd_valid),
        .ms_fwd_stall      (ms_fwd_stall),
        .cancel_busy       (cancel_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The outstanding-response count must never exceed the configured maximum.
    always @(negedge clk) begin
        if (!reset) begin
            assert (dut.cancel_cnt <= MAX_OUTSTANDING)
                else $error("cancel counter overflow: %0d", dut.cancel_cnt);
        end
    end

    task automatic idle_inputs();
        es_to_ms_valid    = 1'b0;
        es_payload        = '0;
        es_ld_op          = LD_NONE;
        es_wait_resp      = 1'b0;
        es_addr_low       = 2'd0;
        es_result         = '0;
        es_dest           = 5'd0;
        es_gr_we          = 1'b0;
        es_cancel_inc     = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        ws_allowin        = 1'b1;
        flush             = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic issue(input logic [LD_OP_W-1:0] op, input logic wt, input logic [1:0] al,
                         input logic [DATA_W-1:0] res, input logic [4:0] dst, input logic we);
        es_to_ms_valid = 1'b1;
        es_ld_op       = op;
        es_wait_resp   = wt;
        es_addr_low    = al;
        es_result      = res;
        es_dest        = dst;
        es_gr_we       = we;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        sample();
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", ms_to_ws_valid); end
        n_cmp++; if (ms_allowin !== 1'b1) begin n_bad++; $display("FAIL rst_allowin got=%b exp=1", ms_allowin); end
        n_cmp++; if (cancel_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", cancel_busy); end
        n_cmp++; if (ms_fwd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_fwd got=%b exp=0", ms_fwd_valid); end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_ld_w();
        logic [PAYLOAD_W-1:0] pl;
        pl = {40'hA5A5A5A5A5, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
        issue(LD_W, 1'b1, 2'd0, 32'h0000_0100, 5'd5, 1'b1);
        es_payload = pl;
        sample();
        n_cmp++; if (ms_allowin !== 1'b1) begin n_bad++; $display("FAIL ldw_allowin got=%b exp=1", ms_allowin); end
        next_cycle();
        idle_inputs();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8899_AABB;
        sample();
        n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_bad++; $display("FAIL ldw_valid got=%b exp=1", ms_to_ws_valid); end
        n_cmp++; if (ms_final_result !== 32'h8899_AABB) begin n_bad++; $display("FAIL ldw_result got=%h exp=8899aabb", ms_final_result); end
        n_cmp++; if (ms_payload !== pl) begin n_bad++; $display("FAIL ldw_payload got=%h exp=%h", ms_payload, pl); end
        n_cmp++; if (ms_dest !== 5'd5 || ms_gr_we !== 1'b1) begin n_bad++; $display("FAIL ldw_dest got=%0d/%b exp=5/1", ms_dest, ms_gr_we); end
        n_cmp++; if (ms_fwd_valid !== 1'b1 || ms_fwd_stall !== 1'b0) begin n_bad++; $display("FAIL ldw_fwd got=%b/%b exp=1/0", ms_fwd_valid, ms_fwd_stall); end
        next_cycle();
        idle_inputs();
        sample();
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_bad++; $display("FAIL ldw_oneshot got=%b exp=0", ms_to_ws_valid); end
        next_cycle();
    endtask

    task automatic run_buf(input string nm, input logic [LD_OP_W-1:0] op, input logic [1:0] al,
                           input logic [DATA_W-1:0] exp);
        issue(op, 1'b1, al, 32'h0, 5'd9, 1'b1);
        next_cycle();
        idle_inputs();
        ws_allowin = 1'b0;
        sample();
        n_cmp++; if (ms_fwd_stall !== 1'b1 || ms_to_ws_valid !== 1'b0) begin n_bad++; $display("FAIL %s_wait got stall=%b valid=%b exp 1/0", nm, ms_fwd_stall, ms_to_ws_valid); end
        next_cycle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8011_2233;
        sample();
        n_cmp++; if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0) begin n_bad++; $display("FAIL %s_resp got valid=%b allowin=%b exp 1/0", nm, ms_to_ws_valid, ms_allowin); end
        n_cmp++; if (ms_final_result !== exp) begin n_bad++; $display("FAIL %s_direct got=%h exp=%h", nm, ms_final_result, exp); end
        next_cycle();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        sample();
        n_cmp++; if (ms_final_result !== exp || ms_allowin !== 1'b0) begin n_bad++; $display("FAIL %s_held got=%h allowin=%b exp=%h/0", nm, ms_final_result, ms_allowin, exp); end
        n_cmp++; if (ms_fwd_stall !== 1'b0) begin n_bad++; $display("FAIL %s_nostall got=%b exp=0", nm, ms_fwd_stall); end
        next_cycle();
        sample();
        next_cycle();
        ws_allowin = 1'b1;
        sample();
        n_cmp++; if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b1) begin n_bad++; $display("FAIL %s_release got allowin=%b valid=%b exp 1/1", nm, ms_allowin, ms_to_ws_valid); end
        n_cmp++; if (ms_final_result !== exp) begin n_bad++; $display("FAIL %s_release_res got=%h exp=%h", nm, ms_final_result, exp); end
        next_cycle();
        sample();
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_bad++; $display("FAIL %s_gone got=%b exp=0", nm, ms_to_ws_valid); end
        idle_inputs();
    endtask

    task automatic test_buffer();
        run_buf("ldb",  LD_B,  2'd3, 32'hFFFF_FF80);
        run_buf("ldbu", LD_BU, 2'd3, 32'h0000_0080);
        run_buf("ldhu", LD_HU, 2'd2, 32'h0000_8011);
        run_buf("ldh",  LD_H,  2'd2, 32'hFFFF_8011);
        run_buf("ldb0", LD_B,  2'd0, 32'h0000_0033);
    endtask

    task automatic test_alu_store();
        issue(LD_NONE, 1'b0, 2'd0, 32'h0000_0042, 5'd7, 1'b1);
        next_cycle();
        issue(LD_NONE, 1'b1, 2'd0, 32'h0000_0077, 5'd0, 1'b0);
        sample();
        n_cmp++; if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'h42) begin n_bad++; $display("FAIL alu got valid=%b res=%h exp 1/42", ms_to_ws_valid, ms_final_result); end
        n_cmp++; if (ms_fwd_valid !== 1'b1 || ms_fwd_stall !== 1'b0) begin n_bad++; $display("FAIL alu_fwd got=%b/%b exp=1/0", ms_fwd_valid, ms_fwd_stall); end
        next_cycle();
        idle_inputs();
        sample();
        n_cmp++; if (ms_to_ws_valid !== 1'b0 || ms_fwd_valid !== 1'b0) begin n_bad++; $display("FAIL st_wait got valid=%b fwd=%b exp 0/0", ms_to_ws_valid, ms_fwd_valid); end
        next_cycle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hFFFF_FFFF;
        sample();
        n_cmp++; if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'h77) begin n_bad++; $display("FAIL st_done got valid=%b res=%h exp 1/77", ms_to_ws_valid, ms_final_result); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_flush_cancel();
        issue(LD_W, 1'b1, 2'd0, 32'h0, 5'd3, 1'b1);
        next_cycle();
        idle_inputs();
        flush = 1'b1;
        sample();
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_bad++; $display("FAIL fl_valid got=%b exp=0", ms_to_ws_valid); end
        next_cycle();
        idle_inputs();
        sample();
        n_cmp++; if (cancel_busy !== 1'b1 || ms_fwd_valid !== 1'b0) begin n_bad++; $display("FAIL fl_busy got busy=%b fwd=%b exp 1/0", cancel_busy, ms_fwd_valid); end
        next_cycle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_DEAD;
        sample();
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_bad++; $display("FAIL fl_drop got=%b exp=0", ms_to_ws_valid); end
        next_cycle();
        idle_inputs();
        issue(LD_W, 1'b1, 2'd0, 32'h0, 5'd3, 1'b1);
        sample();
        n_cmp++; if (cancel_busy !== 1'b0) begin n_bad++; $display("FAIL fl_clear got=%b exp=0", cancel_busy); end
        next_cycle();
        idle_inputs();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_1234;
        sample();
        n_cmp++; if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'h1234) begin n_bad++; $display("FAIL fl_next got valid=%b res=%h exp 1/1234", ms_to_ws_valid, ms_final_result); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_double_cancel();
        issue(LD_W, 1'b1, 2'd0, 32'h0, 5'd4, 1'b1);
        next_cycle();
        idle_inputs();
        flush         = 1'b1;
        es_cancel_inc = 1'b1;
        sample();
        next_cycle();
        idle_inputs();
        issue(LD_W, 1'b1, 2'd0, 32'h0, 5'd4, 1'b1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_1111;
        sample();
        n_cmp++; if (cancel_busy !== 1'b1 || ms_to_ws_valid !== 1'b0) begin n_bad++; $display("FAIL dc_drop1 got busy=%b valid=%b exp 1/0", cancel_busy, ms_to_ws_valid); end
        next_cycle();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h0000_5555;
        sample();
        n_cmp++; if (cancel_busy !== 1'b1 || ms_to_ws_valid !== 1'b0 || ms_fwd_stall !== 1'b1) begin n_bad++; $display("FAIL dc_drop2 got busy=%b valid=%b stall=%b exp 1/0/1", cancel_busy, ms_to_ws_valid, ms_fwd_stall); end
        next_cycle();
        data_sram_rdata = 32'h0000_CAFE;
        sample();
        n_cmp++; if (cancel_busy !== 1'b0 || ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'hCAFE) begin n_bad++; $display("FAIL dc_third got busy=%b valid=%b res=%h exp 0/1/cafe", cancel_busy, ms_to_ws_valid, ms_final_result); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_flush_same_cycle();
        issue(LD_W, 1'b1, 2'd0, 32'h0, 5'd6, 1'b1);
        next_cycle();
        idle_inputs();
        flush             = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_BEEF;
        sample();
        n_cmp++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin n_bad++; $display("FAIL fs_valid got valid=%b allowin=%b exp 0/1", ms_to_ws_valid, ms_allowin); end
        next_cycle();
        idle_inputs();
        issue(LD_W, 1'b1, 2'd0, 32'h0, 5'd6, 1'b1);
        sample();
        n_cmp++; if (cancel_busy !== 1'b0) begin n_bad++; $display("FAIL fs_busy got=%b exp=0", cancel_busy); end
        next_cycle();
        idle_inputs();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_2222;
        sample();
        n_cmp++; if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'h2222) begin n_bad++; $display("FAIL fs_next got valid=%b res=%h exp 1/2222", ms_to_ws_valid, ms_final_result); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        issue(LD_W, 1'b1, 2'd0, 32'h0, 5'd8, 1'b1);
        next_cycle();
        idle_inputs();
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_3333;
        next_cycle();
        data_sram_data_ok = 1'b0;
        es_cancel_inc     = 1'b1;
        next_cycle();
        es_cancel_inc = 1'b0;
        reset         = 1'b1;
        sample();
        n_cmp++; if (cancel_busy !== 1'b1 || ms_allowin !== 1'b0) begin n_bad++; $display("FAIL rm_pre got busy=%b allowin=%b exp 1/0", cancel_busy, ms_allowin); end
        next_cycle();
        reset = 1'b0;
        sample();
        n_cmp++; if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0) begin n_bad++; $display("FAIL rm_post got allowin=%b valid=%b exp 1/0", ms_allowin, ms_to_ws_valid); end
        n_cmp++; if (cancel_busy !== 1'b0 || ms_fwd_valid !== 1'b0) begin n_bad++; $display("FAIL rm_clear got busy=%b fwd=%b exp 0/0", cancel_busy, ms_fwd_valid); end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        test_reset();
        test_ld_w();
        test_buffer();
        test_alu_store();
        test_flush_cancel();
        test_double_cancel();
        test_flush_same_cycle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_resp_stage.md
Name: mem_resp_stage

Overview:
- Parametrised MEM pipeline stage between EX and WB.
- Unlike the current fixed single-cycle stage, it handles a true split-transaction data-SRAM response path:
  - waits for data_ok;
  - buffers rdata while WB stalls;
  - discards responses owed to flushed loads through a cancel counter.
- Also performs load byte/halfword extraction and drives the DS forwarding info.

Parameters:
- DATA_W, 32, datapath and rdata width (multiple of 16).
- PAYLOAD_W, 168, opaque sideband (pc, csr, excp fields) passed EX→WB unchanged.
- MAX_OUTSTANDING, 2, maximum data requests in flight; sizes the cancel counter to clog2(MAX_OUTSTANDING+1) bits.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- es_to_ms_valid  in  1  EX holds a valid instruction.
- ms_allowin  out  1  MEM accepts an instruction this cycle.
- es_payload  in  PAYLOAD_W  opaque sideband.
- es_ld_op  in  3  load type: 0 none, 1 ld.b, 2 ld.bu, 3 ld.h, 4 ld.hu, 5 ld.w.
- es_wait_resp  in  1  the instruction's request got addr_ok and a data_ok is owed (loads and stores).
- es_addr_low  in  2  address bits [1:0].
- es_result  in  DATA_W  ALU/mul/div/csr result for non-loads.
- es_dest  in  5  destination register.
- es_gr_we  in  1  register write enable.
- es_cancel_inc  in  1  EX is dropping, on flush, an instruction whose data_ok is still owed.
- data_sram_data_ok  in  1  response valid.
- data_sram_rdata  in  DATA_W  response data.
- ws_allowin  in  1  WB ready.
- flush  in  1  exception/ertn flush.
- ms_to_ws_valid  out  1  valid to WB.
- ms_payload  out  PAYLOAD_W  registered sideband.
- ms_dest  out  5  registered destination.
- ms_gr_we  out  1  registered write enable.
- ms_final_result  out  DATA_W  result to WB and forwarding.
- ms_fwd_valid  out  1  ms_valid && ms_gr_we && dest!=0.
- ms_fwd_stall  out  1  ms_fwd_valid && load result not yet available.
- cancel_busy  out  1  cancel_cnt != 0.

Behaviour:
- Reset: ms_valid=0, buf_valid=0, cancel_cnt=0. Hence ms_to_ws_valid=0, ms_allowin=1, cancel_busy=0, ms_fwd_valid=0. Data registers are don't-care.
- Own response: own_ok = data_sram_data_ok && cancel_cnt==0 && ms_valid && wait_r && !buf_valid.
  - A data_ok with cancel_cnt>0 is discarded and decrements the counter.
  - Responses return in request order.
- ms_ready_go = !wait_r || buf_valid || own_ok.
- ms_to_ws_valid = ms_valid && ms_ready_go && !flush.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin) || flush.
- Capture: when es_to_ms_valid && ms_allowin && !flush, register all es_* fields, with wait_r=es_wait_resp and buf_valid cleared. ms_valid <= es_to_ms_valid && !flush.
- Buffer: own_ok && !ws_allowin → buf <= rdata, buf_valid <= 1. The buffer is cleared when the instruction leaves MEM.
- Zero latency when data_ok arrives and WB is ready in the same cycle: rdata is used combinationally.
- Flush handling:
  - On flush, ms_valid <= 0 and buf_valid <= 0.
  - If ms_valid && wait_r && !buf_valid && !own_ok, the owed response is counted: cancel_cnt += 1.
  - A data_ok consumed in the flush cycle (own_ok) is discarded and not counted.
- Counter update per cycle: cancel_cnt += (flush-owed) + es_cancel_inc − (data_ok && cancel_cnt!=0). Simultaneous increment and decrement net correctly.
- Exceeding MAX_OUTSTANDING is illegal; the bench asserts against it.
- Load extraction, with data = buf_valid ? buf : rdata:
  - byte lane = addr_low;
  - halfword lane = addr_low[1];
  - sign- or zero-extend to DATA_W per es_ld_op.
- Result: ms_final_result = load value if ld_op!=0, else result_r.
- Misaligned halfword addresses never reach this stage valid-without-exception; extraction still uses addr_low[1].
- Stores: wait_r=1, ld_op=0. The stage waits for data_ok, and the result is result_r.

Decomposition:
- Package mem_pkg: LD_* op encodings, the LD_OP_W=3 constant, and the cancel counter width function.
- Sub-module mem_load_align: combinational extraction (data, addr_low, ld_op) → DATA_W result.

Test Plan:
- ld.w at addr 0x100, data_ok the cycle after capture with rdata=0x8899AABB, ws_allowin=1 → ms_to_ws_valid for 1 cycle, ms_final_result=0x8899AABB.
- ld.b with addr_low=3, rdata=0x80112233, ws_allowin=0 for 3 cycles → buf_valid set; on release, result=0xFFFFFF80 and ms_allowin rises the same cycle. ld.bu → 0x00000080; ld.hu with addr_low=2 → 0x00008011.
- Load waiting, flush asserted before data_ok → next cycle ms_valid=0, cancel_busy=1. The following data_ok (0xDEAD) is dropped and cancel_busy=0. A new ld.w then returns 0x1234 correctly.
- Flush while es_cancel_inc=1 and MEM also owes → cancel_cnt=2. Two data_oks are dropped, and the third is delivered.
- data_ok in the same cycle as flush for the current load → cancel_cnt stays 0 and ms_to_ws_valid=0.
- Reset asserted with buf_valid=1 and cancel_cnt=1 → next cycle all cleared, ms_allowin=1.
